alu_issue_unit: RTL and testbench

- Initiator/driver side of the combinational ALU interface.
- Accepts tagged ALU commands from an upstream valid/ready stream and buffers them in a small FIFO.
- Drives one command at a time onto registered ALU operand/control outputs, holds them stable for the required evaluation time, captures result/zero/overflow, and returns a tagged response over a downstream valid/ready stream.
- Sits between the instruction/test sequencer and the ALU datapath.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_issue_unit.sv | 151 +++++++++++++++
 tb/tb_alu_issue_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and issue-FSM state type for the ALU issue unit.
package alu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_MUL = 5'b01000;
    localparam logic [4:0] ALU_DIV = 5'b01100;
    localparam int ALU_LOGIC_BIT  = 4;
    localparam int ALU_SIGNED_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } issue_state_t;

    // MUL and DIV are the multicycle paths through the ALU.
    function automatic logic is_muldiv(input logic [4:0] ctrl);
        return !ctrl[ALU_LOGIC_BIT] && ctrl[3];
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty are derived from an occupancy count one bit wider than the pointers.
module alu_cmd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push_ok;
    logic              pop_ok;

    // A push is refused whenever full, even if a pop frees a slot in the same cycle.
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues buffered, tagged commands to a combinational ALU one at a time and returns tagged responses.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4,
    parameter int MULDIV_WAIT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [WIDTH-1:0]          cmd_a,
    input  logic [WIDTH-1:0]          cmd_b,
    input  logic [4:0]                cmd_ctrl,
    input  logic [$clog2(WIDTH)-1:0]  cmd_shamt,
    input  logic [TAG_W-1:0]          cmd_tag,
    output logic [WIDTH-1:0]          alu_operand_a,
    output logic [WIDTH-1:0]          alu_operand_b,
    output logic [4:0]                alu_control,
    output logic [$clog2(WIDTH)-1:0]  alu_shift_amount,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_overflow,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_overflow,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic                      busy,
    output logic [15:0]               ovf_count
);
    localparam int SW = $clog2(WIDTH);
    localparam int PW = TAG_W + SW + 5 + 2*WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;

    logic [PW-1:0]      fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               fifo_pop;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic [4:0]         head_ctrl;
    logic [SW-1:0]      head_shamt;
    logic [TAG_W-1:0]   head_tag;

    issue_state_t       state_reg;
    logic [WW-1:0]      wait_cnt_reg;
    logic [WIDTH-1:0]   alu_a_reg;
    logic [WIDTH-1:0]   alu_b_reg;
    logic [4:0]         alu_ctrl_reg;
    logic [SW-1:0]      alu_shamt_reg;
    logic [TAG_W-1:0]   alu_tag_reg;
    logic               rsp_valid_reg;
    logic [WIDTH-1:0]   rsp_result_reg;
    logic               rsp_zero_reg;
    logic               rsp_overflow_reg;
    logic [TAG_W-1:0]   rsp_tag_reg;
    logic [15:0]        ovf_count_reg;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
    assign {head_tag, head_shamt, head_ctrl, head_b, head_a} = fifo_rd_data;

    alu_cmd_fifo #(
        .DATA_W (PW),
        .DEPTH  (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_tag, cmd_shamt, cmd_ctrl, cmd_b, cmd_a}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            wait_cnt_reg     <= '0;
            alu_a_reg        <= '0;
            alu_b_reg        <= '0;
            alu_ctrl_reg     <= '0;
            alu_shamt_reg    <= '0;
            alu_tag_reg      <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_result_reg   <= '0;
            rsp_zero_reg     <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            rsp_tag_reg      <= '0;
            ovf_count_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a_reg     <= head_a;
                        alu_b_reg     <= head_b;
                        alu_ctrl_reg  <= head_ctrl;
                        alu_shamt_reg <= head_shamt;
                        alu_tag_reg   <= head_tag;
                        wait_cnt_reg  <= is_muldiv(head_ctrl) ? WW'(MULDIV_WAIT) : '0;
                        state_reg     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Operands stay put until the multicycle hold has elapsed, then the ALU outputs are sampled.
                    if (wait_cnt_reg != '0) begin
                        wait_cnt_reg <= wait_cnt_reg - WW'(1);
                    end else begin
                        rsp_result_reg   <= alu_result;
                        rsp_zero_reg     <= alu_zero;
                        rsp_overflow_reg <= alu_overflow;
                        rsp_tag_reg      <= alu_tag_reg;
                        rsp_valid_reg    <= 1'b1;
                        if (alu_overflow && (ovf_count_reg != 16'hFFFF)) begin
                            ovf_count_reg <= ovf_count_reg + 16'd1;
                        end
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign alu_operand_a    = alu_a_reg;
    assign alu_operand_b    = alu_b_reg;
    assign alu_control      = alu_ctrl_reg;
    assign alu_shift_amount = alu_shamt_reg;
    assign rsp_valid        = rsp_valid_reg;
    assign rsp_result       = rsp_result_reg;
    assign rsp_zero         = rsp_zero_reg;
    assign rsp_overflow     = rsp_overflow_reg;
    assign rsp_tag          = rsp_tag_reg;
    assign busy             = (state_reg != ST_IDLE) || (fifo_count != '0);
    assign ovf_count        = ovf_count_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Random and directed stimulus for alu_issue_unit against a queue-based response model and a behavioural ALU.
module tb_alu_issue_unit;
    localparam int WIDTH       = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int TAG_W       = 4;
    localparam int MULDIV_WAIT = 2;

    typedef struct packed {
        logic        ovf;
        logic        zero;
        logic [31:0] result;
    } alu_res_t;

    typedef struct {
        alu_res_t         res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_a = '0;
    logic [31:0]       cmd_b = '0;
    logic [4:0]        cmd_ctrl = '0;
    logic [4:0]        cmd_shamt = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic [31:0]       alu_operand_a;
    logic [31:0]       alu_operand_b;
    logic [4:0]        alu_control;
    logic [4:0]        alu_shift_amount;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic              alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_overflow;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;
    logic [15:0]       ovf_count;

    int err_cnt = 0;
    int chk_cnt = 0;
    exp_t exp_q[$];
    int model_ovf = 0;
    int push_count = 0;
    int rsp_count = 0;
    logic [31:0] a_hist [8];

    alu_issue_unit #(
        .WIDTH       (WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TAG_W       (TAG_W),
        .MULDIV_WAIT (MULDIV_WAIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_a            (cmd_a),
        .cmd_b            (cmd_b),
        .cmd_ctrl         (cmd_ctrl),
        .cmd_shamt        (cmd_shamt),
        .cmd_tag          (cmd_tag),
        .alu_operand_a    (alu_operand_a),
        .alu_operand_b    (alu_operand_b),
        .alu_control      (alu_control),
        .alu_shift_amount (alu_shift_amount),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .alu_overflow     (alu_overflow),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_zero         (rsp_zero),
        .rsp_overflow     (rsp_overflow),
        .rsp_tag          (rsp_tag),
        .busy             (busy),
        .ovf_count        (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference ALU behaviour straight from the opcode definitions.
    function automatic alu_res_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] ctrl, input logic [4:0] shamt);
        alu_res_t r;
        logic [32:0] wide;
        longint q;
        r.ovf = 1'b0;
        r.result = '0;
        if (ctrl[4]) begin
            case (ctrl[3:2])
                2'b00:   r.result = a & b;
                2'b01:   r.result = a | b;
                2'b10:   r.result = a ^ b;
                default: r.result = a << shamt;
            endcase
        end else begin
            case (ctrl[3:2])
                2'b00: begin
                    wide = {1'b0, a} + {1'b0, b};
                    r.result = wide[31:0];
                    r.ovf = ctrl[0] ? ((a[31] == b[31]) && (r.result[31] != a[31])) : wide[32];
                end
                2'b01: begin
                    r.result = a - b;
                    r.ovf = ctrl[0] ? ((a[31] != b[31]) && (r.result[31] != a[31])) : (a < b);
                end
                2'b10: r.result = a * b;
                default: begin
                    if (b == 0) begin
                        r.result = 32'hFFFF_FFFF;
                    end else if (ctrl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        r.result = 32'h8000_0000;
                        r.ovf = 1'b1;
                    end else if (ctrl[0]) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r.result = q[31:0];
                    end else begin
                        r.result = a / b;
                    end
                end
            endcase
        end
        r.zero = (r.result == 0);
        return r;
    endfunction

    // Behavioural ALU: MUL/DIV outputs are garbage until operands have been held long enough.
    logic [73:0] alu_bus;
    logic [73:0] prev_bus = '0;
    int          hold_cnt = 0;
    int          stable_cnt;
    alu_res_t    alu_cur;
    logic        alu_early;

    assign alu_bus    = {alu_operand_a, alu_operand_b, alu_control, alu_shift_amount};
    assign stable_cnt = (alu_bus === prev_bus) ? hold_cnt + 1 : 0;
    assign alu_cur    = alu_fn(alu_operand_a, alu_operand_b, alu_control, alu_shift_amount);
    assign alu_early  = !alu_control[4] && alu_control[3] && (stable_cnt < MULDIV_WAIT);
    assign alu_result   = alu_early ? ~alu_cur.result : alu_cur.result;
    assign alu_zero     = alu_early ? ~alu_cur.zero : alu_cur.zero;
    assign alu_overflow = alu_early ? ~alu_cur.ovf : alu_cur.ovf;

    initial begin
        forever begin
            @(posedge clk);
            hold_cnt = (alu_bus === prev_bus) ? ((hold_cnt < 1000) ? hold_cnt + 1 : hold_cnt) : 0;
            prev_bus = alu_bus;
        end
    end

    // Scoreboard: predicts on accepted commands, checks on completed response handshakes.
    initial begin
        exp_t e;
        exp_t got_prev;
        logic stall_prev;
        stall_prev = 1'b0;
        got_prev.res = '0;
        got_prev.tag = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("stall_valid", rsp_valid, 1'b1);
                    check_eq("stall_result", {rsp_overflow, rsp_zero, rsp_result}, got_prev.res);
                    check_eq("stall_tag", rsp_tag, got_prev.tag);
                end
                if (cmd_valid && cmd_ready) begin
                    e.res = alu_fn(cmd_a, cmd_b, cmd_ctrl, cmd_shamt);
                    e.tag = cmd_tag;
                    exp_q.push_back(e);
                    push_count++;
                    if (e.res.ovf && model_ovf < 65535) model_ovf++;
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_count++;
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_unexpected", rsp_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rsp_result", rsp_result, e.res.result);
                        check_eq("rsp_zero", rsp_zero, e.res.zero);
                        check_eq("rsp_ovf", rsp_overflow, e.res.ovf);
                        check_eq("rsp_tag", rsp_tag, e.tag);
                        $display("rsp tag=%0d result=%h zero=%0b ovf=%0b", rsp_tag, rsp_result, rsp_zero, rsp_overflow);
                    end
                end
                stall_prev = rsp_valid && !rsp_ready;
                got_prev.res = {rsp_overflow, rsp_zero, rsp_result};
                got_prev.tag = rsp_tag;
            end
        end
    end

    // Accepts one command into an idle unit and measures cycles until rsp_valid.
    task automatic issue_timed(input logic [31:0] a, input logic [31:0] b, input logic [4:0] ctrl,
                               input logic [TAG_W-1:0] tag, output int lat);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_ctrl = ctrl; cmd_shamt = '0; cmd_tag = tag; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat < 8) a_hist[lat] = alu_operand_a;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_busy", busy, 1'b0);
    endtask

    initial begin
        int lat;
        int acc;
        int base;
        #12;
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ovf_count", ovf_count, 16'd0);
        check_eq("rst_alu_a", alu_operand_a, 32'd0);
        check_eq("rst_alu_ctrl", alu_control, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue_timed(32'd5, 32'd3, 5'b00000, 4'd1, lat);
        check_eq("add_latency", lat, 2);
        check_eq("add_result", rsp_result, 32'd8);
        check_eq("add_zero", rsp_zero, 1'b0);
        check_eq("add_ovf", rsp_overflow, 1'b0);
        check_eq("add_tag", rsp_tag, 4'd1);
        @(posedge clk);
        #1;
        check_eq("add_consumed", rsp_valid, 1'b0);
        drain();

        issue_timed(32'h8000_0000, 32'd1, 5'b00101, 4'd2, lat);
        check_eq("ssub_latency", lat, 2);
        check_eq("ssub_result", rsp_result, 32'h7FFF_FFFF);
        check_eq("ssub_ovf", rsp_overflow, 1'b1);
        check_eq("ssub_ovf_count", ovf_count, 16'd1);
        drain();

        issue_timed(32'd6, 32'd7, 5'b01000, 4'd3, lat);
        check_eq("mul_latency", lat, 2 + MULDIV_WAIT);
        check_eq("mul_result", rsp_result, 32'd42);
        for (int i = 1; i <= 3; i++) check_eq("mul_hold_a", a_hist[i], 32'd6);
        drain();

        issue_timed(32'h1234, 32'h1234, 5'b00100, 4'd4, lat);
        check_eq("zero_result", rsp_result, 32'd0);
        check_eq("zero_flag", rsp_zero, 1'b1);
        drain();

        // Backpressure: fill RESP plus the FIFO, then release.
        rsp_ready = 1'b0;
        acc = 0;
        base = rsp_count;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            cmd_a = t; cmd_b = t * 3; cmd_ctrl = 5'b00000; cmd_tag = t[TAG_W-1:0]; cmd_valid = 1'b1;
            if (cmd_ready) acc++;
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("bp_accepted", acc, 5);
        check_eq("bp_cmd_ready", cmd_ready, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("bp_rsp_tag0", rsp_tag, 4'd0);
        rsp_ready = 1'b1;
        drain();
        check_eq("bp_rsp_count", rsp_count - base, 5);

        // Reset while the first of four commands is still in DRIVE.
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            cmd_a = 32'd9 + t; cmd_b = 32'd2; cmd_ctrl = (t == 0) ? 5'b01000 : 5'b00000;
            cmd_tag = 4'd8 + t[TAG_W-1:0]; cmd_valid = 1'b1;
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_ovf = 0;
        push_count = 0;
        rsp_count = 0;
        check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("mid_rst_ovf_count", ovf_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_rst_no_rsp", rsp_count, 0);
        check_eq("post_rst_busy", busy, 1'b0);

        // Randomized traffic with random downstream stalls.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       cmd_a = 32'h8000_0000;
                1:       cmd_a = 32'hFFFF_FFFF;
                2:       cmd_a = $urandom_range(0, 15);
                default: cmd_a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       cmd_b = 32'd1;
                1:       cmd_b = 32'hFFFF_FFFF;
                2:       cmd_b = $urandom_range(0, 3);
                default: cmd_b = $urandom;
            endcase
            cmd_ctrl  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1))};
            cmd_shamt = 5'($urandom_range(0, 31));
            cmd_tag   = TAG_W'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        check_eq("rand_rsp_count", rsp_count, push_count);
        check_eq("rand_ovf_count", ovf_count, 16'(model_ovf));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
